// File: rtl/sram_bus_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// sram_bus_pkg
// Shared definitions for the SRAM bus controller and its arbiter:
//   state_e      - controller state encoding (ST_IDLE, ST_ACCESS, ST_DONE)
//   ARB_FIXED/RR - arbitration mode selectors for the ARB_MODE parameter
//   GRANT_I/D    - encoding of the granted master (instruction / data)
//   WAIT_CNT_W   - wait-counter width, wide enough for 0..15 wait states
//   arb_pick()   - two-request grant decision shared by the arbiter
// -----------------------------------------------------------------------------
package sram_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam int   ARB_FIXED  = 0;
    localparam int   ARB_RR     = 1;

    localparam logic GRANT_I    = 1'b0;
    localparam logic GRANT_D    = 1'b1;

    localparam int   WAIT_CNT_W = $clog2(16);

    // Returns 1 when the data port wins. A lone requester always wins; on a
    // tie, fixed mode favours data and round-robin favours whichever port was
    // not granted last.
    function automatic logic arb_pick(
        input logic req_ins,
        input logic req_dat,
        input logic rr_mode,
        input logic last_grant
    );
        logic pick_d;
        if (req_ins && req_dat) begin
            if (rr_mode) begin
                pick_d = (last_grant == GRANT_I);
            end else begin
                pick_d = 1'b1;
            end
        end else begin
            pick_d = req_dat;
        end
        return pick_d;
    endfunction

endpackage

// File: rtl/sram_bus_ctrl_arb.sv
// -----------------------------------------------------------------------------
// sram_arb
// Two-request arbiter between instruction fetch and data port.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   req_ins_i      - instruction port request
//   req_dat_i      - data port request
//   accept_i       - controller takes the current grant this cycle
//   grant_valid_o  - at least one port is requesting
//   grant_d_o      - 1 = data port granted, 0 = instruction port granted
// last_grant only moves when the controller actually accepts a grant, so a
// request seen outside IDLE does not disturb the round-robin order.
// -----------------------------------------------------------------------------
module sram_arb
    import sram_bus_pkg::*;
#(
    parameter int ARB_MODE = ARB_FIXED
) (
    input  logic clk,
    input  logic rst,
    input  logic req_ins_i,
    input  logic req_dat_i,
    input  logic accept_i,
    output logic grant_valid_o,
    output logic grant_d_o
);

    localparam logic RR_EN = (ARB_MODE == ARB_RR) ? 1'b1 : 1'b0;

    logic last_grant_q;
    logic last_grant_d;

    // Grant decision and next value of the last-grant flop.
    always_comb begin
        grant_valid_o = req_ins_i | req_dat_i;
        grant_d_o     = arb_pick(req_ins_i, req_dat_i, RR_EN, last_grant_q);
        last_grant_d  = last_grant_q;
        if (accept_i && grant_valid_o) begin
            last_grant_d = grant_d_o ? GRANT_D : GRANT_I;
        end else begin
            last_grant_d = last_grant_q;
        end
    end

    // Last-grant flop; after reset the instruction port counts as last served.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= GRANT_I;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/sram_bus_ctrl.sv
// -----------------------------------------------------------------------------
// sram_bus_ctrl
// Registered SRAM controller with a two-master arbiter (instruction fetch and
// data port) in front of one asynchronous SRAM bank.
// Ports:
//   clk, rst                  - clock, asynchronous active-high reset
//   i_req/i_addr              - instruction read request (held until i_ack)
//   i_ack/i_rdata             - one-cycle completion pulse and fetched word
//   d_req/d_we/d_sel/d_addr/d_wdata - data request with qualifiers
//   d_ack/d_rdata             - one-cycle completion pulse and read word
//   ram_data                  - bidirectional SRAM data bus
//   ram_addr/ram_be_n/ram_ce_n/ram_oe_n/ram_we_n - registered SRAM strobes
//   busy                      - controller is not in IDLE
// Transaction timing: IDLE (grant) -> ACCESS for WAIT_CYCLES+1 cycles -> DONE
// (ack). For writes, DONE raises we_n while ce_n, byte enables and the data
// drive are held one more cycle to give the SRAM write-data hold time.
// -----------------------------------------------------------------------------
module sram_bus_ctrl
    import sram_bus_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1,
    parameter int ARB_MODE    = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i_req,
    input  logic [31:0]         i_addr,
    output logic                i_ack,
    output logic [DATA_W-1:0]   i_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_sel,
    input  logic [31:0]         d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_ack,
    output logic [DATA_W-1:0]   d_rdata,
    inout  wire  [DATA_W-1:0]   ram_data,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic [DATA_W/8-1:0] ram_be_n,
    output logic                ram_ce_n,
    output logic                ram_oe_n,
    output logic                ram_we_n,
    output logic                busy
);

    localparam int NB = DATA_W / 8;
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

    state_e                state_q;
    logic [WAIT_CNT_W-1:0] wait_q;
    logic                  grant_d_q;
    logic                  we_q;
    logic [DATA_W-1:0]     wdata_q;
    logic                  ram_drive_q;
    logic [ADDR_W-1:0]     ram_addr_q;
    logic [NB-1:0]         ram_be_n_q;
    logic                  ram_ce_n_q;
    logic                  ram_oe_n_q;
    logic                  ram_we_n_q;
    logic                  i_ack_q;
    logic                  d_ack_q;
    logic [DATA_W-1:0]     i_rdata_q;
    logic [DATA_W-1:0]     d_rdata_q;
    logic                  busy_q;

    logic                  grant_valid;
    logic                  grant_d;
    logic                  accept;
    logic                  d_write;

    // Byte-offset and upper address bits are not part of the SRAM word address.
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    assign accept  = (state_q == ST_IDLE) && grant_valid;
    assign d_write = grant_d && d_we;

    sram_arb #(
        .ARB_MODE (ARB_MODE)
    ) u_arb (
        .clk           (clk),
        .rst           (rst),
        .req_ins_i     (i_req),
        .req_dat_i     (d_req),
        .accept_i      (accept),
        .grant_valid_o (grant_valid),
        .grant_d_o     (grant_d)
    );

    // Controller FSM; every SRAM strobe, ack and read-data output is a flop here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wait_q      <= '0;
            grant_d_q   <= GRANT_I;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            ram_drive_q <= 1'b0;
            ram_addr_q  <= '0;
            ram_be_n_q  <= {NB{1'b1}};
            ram_ce_n_q  <= 1'b1;
            ram_oe_n_q  <= 1'b1;
            ram_we_n_q  <= 1'b1;
            i_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            i_ack_q <= 1'b0;
            d_ack_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid) begin
                        state_q     <= ST_ACCESS;
                        wait_q      <= WAIT_LOAD;
                        busy_q      <= 1'b1;
                        grant_d_q   <= grant_d;
                        we_q        <= d_write;
                        wdata_q     <= d_wdata;
                        ram_addr_q  <= grant_d ? d_addr[ADDR_W+1:2] : i_addr[ADDR_W+1:2];
                        // Reads always fetch the full word, whatever d_sel says.
                        ram_be_n_q  <= d_write ? ~d_sel : {NB{1'b0}};
                        ram_ce_n_q  <= 1'b0;
                        ram_oe_n_q  <= d_write;
                        ram_we_n_q  <= ~d_write;
                        ram_drive_q <= d_write;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ACCESS: begin
                    if (wait_q == '0) begin
                        state_q <= ST_DONE;
                        i_ack_q <= ~grant_d_q;
                        d_ack_q <= grant_d_q;
                        if (we_q) begin
                            // Hold ce_n, be_n and the bus for one more cycle.
                            ram_we_n_q <= 1'b1;
                        end else begin
                            ram_ce_n_q <= 1'b1;
                            ram_oe_n_q <= 1'b1;
                            if (grant_d_q) begin
                                d_rdata_q <= ram_data;
                            end else begin
                                i_rdata_q <= ram_data;
                            end
                        end
                    end else begin
                        wait_q <= wait_q - WAIT_CNT_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    ram_drive_q <= 1'b0;
                    ram_be_n_q  <= {NB{1'b1}};
                    ram_ce_n_q  <= 1'b1;
                    ram_oe_n_q  <= 1'b1;
                    ram_we_n_q  <= 1'b1;
                end
                default: begin
                    state_q     <= ST_IDLE;
                    busy_q      <= 1'b0;
                    ram_drive_q <= 1'b0;
                    ram_be_n_q  <= {NB{1'b1}};
                    ram_ce_n_q  <= 1'b1;
                    ram_oe_n_q  <= 1'b1;
                    ram_we_n_q  <= 1'b1;
                end
            endcase
        end
    end

    assign ram_data = ram_drive_q ? wdata_q : {DATA_W{1'bz}};
    assign ram_addr = ram_addr_q;
    assign ram_be_n = ram_be_n_q;
    assign ram_ce_n = ram_ce_n_q;
    assign ram_oe_n = ram_oe_n_q;
    assign ram_we_n = ram_we_n_q;
    assign i_ack    = i_ack_q;
    assign d_ack    = d_ack_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign busy     = busy_q;

endmodule
